// File: rtl/full_adder_sr_fsm.sv
// ----------------------------------------------------------------------------
// full_adder_sr_fsm
//
// Bit-serial 8-bit adder. Operands A and B are captured into right-shifting
// registers when an addition starts. A single full adder then consumes one bit
// pair per clock, LSB first, for eight clocks. A three-state controller
// sequences the work: IDLE, SHIFT, DONE.
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   rst       in   1  synchronous active-high reset
//   start     in   1  begin an addition (only looked at in IDLE)
//   data_a    in   8  operand A, captured on the accepted start edge
//   data_b    in   8  operand B, captured on the accepted start edge
//   sum_out   out  1  registered serial sum bit, LSB first
//   carry_out out  1  registered running carry (final carry after completion)
//   done      out  1  registered one-cycle completion pulse
//   a_bit     out  1  operand-A bit presented to the adder (0 outside SHIFT)
//   b_bit     out  1  operand-B bit presented to the adder (0 outside SHIFT)
// ----------------------------------------------------------------------------
module full_adder_sr_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       sum_out,
  output logic       carry_out,
  output logic       done,
  output logic       a_bit,
  output logic       b_bit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Majority of three inputs: the carry out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    maj3 = (x & y) | (x & z) | (y & z);
  endfunction

  // Odd parity of three inputs: the sum out of a full adder.
  function automatic logic xor3(input logic x, input logic y, input logic z);
    xor3 = x ^ y ^ z;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] sr_a_q, sr_a_d;
  logic [7:0] sr_b_q, sr_b_d;
  logic       carry_q, carry_d;
  logic       sum_q, sum_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  // Full-adder result for the bit pair currently at the bottom of the shifters.
  logic fa_sum_s;
  logic fa_carry_s;

  // Single full adder working on the LSBs of the shift registers.
  always_comb begin
    fa_sum_s   = xor3(sr_a_q[0], sr_b_q[0], carry_q);
    fa_carry_s = maj3(sr_a_q[0], sr_b_q[0], carry_q);
  end

  // Next-state and datapath update for every register.
  always_comb begin
    state_d = state_q;
    sr_a_d  = sr_a_q;
    sr_b_d  = sr_b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_a_d  = data_a;
          sr_b_d  = data_b;
          carry_d = 1'b0;
          sum_d   = 1'b0;
          cnt_d   = 3'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        sum_d   = fa_sum_s;
        carry_d = fa_carry_s;
        sr_a_d  = {1'b0, sr_a_q[7:1]};
        sr_b_d  = {1'b0, sr_b_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Last bit pair consumed; done rises together with the DONE state.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_a_q  <= 8'd0;
      sr_b_q  <= 8'd0;
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_a_q  <= sr_a_d;
      sr_b_q  <= sr_b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Operand bits are only exposed while the adder is actually consuming them.
  always_comb begin
    if (state_q == ST_SHIFT) begin
      a_bit = sr_a_q[0];
      b_bit = sr_b_q[0];
    end else begin
      a_bit = 1'b0;
      b_bit = 1'b0;
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = carry_q;
  assign done      = done_q;

endmodule

// File: tb/tb_full_adder_sr_fsm.sv
module tb_full_adder_sr_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       sum_out;
  logic       carry_out;
  logic       done;
  logic       a_bit;
  logic       b_bit;

  int n_checks;
  int n_fails;

  full_adder_sr_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_a    (data_a),
    .data_b    (data_b),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .done      (done),
    .a_bit     (a_bit),
    .b_bit     (b_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"},   {31'd0, sum_out},   32'd0);
    check({tag, "_carry"}, {31'd0, carry_out}, 32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_abit"},  {31'd0, a_bit},     32'd0);
    check({tag, "_bbit"},  {31'd0, b_bit},     32'd0);
  endtask

  // One full transaction. exp_sum/exp_cout are hand-computed.
  // If inject is set, start with zero operands is pulsed in SHIFT cycle 3.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input logic exp_cout, input bit inject);
    logic [8:0] part;
    start  = 1'b1;
    data_a = a;
    data_b = b;
    tick();  // E0
    start  = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_abit%0d", tag, k), {31'd0, a_bit}, {31'd0, a[k]});
      check($sformatf("%s_bbit%0d", tag, k), {31'd0, b_bit}, {31'd0, b[k]});
      check($sformatf("%s_busy%0d", tag, k), {31'd0, done},  32'd0);
      if (inject && k == 3) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();  // E(k+1)
      start = 1'b0;
      // Carry out of bit k: bit k+1 of the sum of the low k+1 operand bits.
      part = {1'b0, a & ((9'd2 << k) - 9'd1)} + {1'b0, b & ((9'd2 << k) - 9'd1)};
      check($sformatf("%s_sum%0d", tag, k),   {31'd0, sum_out},   {31'd0, exp_sum[k]});
      check($sformatf("%s_carry%0d", tag, k), {31'd0, carry_out}, {31'd0, part[k+1]});
    end
    check({tag, "_done"},   {31'd0, done},      32'd1);
    check({tag, "_cfinal"}, {31'd0, carry_out}, {31'd0, exp_cout});
    check({tag, "_abit_dn"}, {31'd0, a_bit},    32'd0);
    tick();  // E9 -> IDLE
    check({tag, "_done_drop"}, {31'd0, done},      32'd0);
    check({tag, "_hold_sum"},  {31'd0, sum_out},   {31'd0, exp_sum[7]});
    check({tag, "_hold_c"},    {31'd0, carry_out}, {31'd0, exp_cout});
    tick();
    check({tag, "_idle_done"}, {31'd0, done},      32'd0);
    check({tag, "_idle_c"},    {31'd0, carry_out}, {31'd0, exp_cout});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst    = 1'b1;
    start  = 1'b1;
    data_a = 8'hFF;
    data_b = 8'hFF;

    // Reset held two cycles with start high.
    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero($sformatf("quiet%0d", i));
    end

    run_add("aa55", 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);
    run_add("f42f", 8'hF4, 8'h2F, 8'h23, 1'b1, 1'b0);
    run_add("ff01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_add("inj",  8'hF4, 8'h2F, 8'h23, 1'b1, 1'b1);

    // Reset during the 4th SHIFT cycle.
    start  = 1'b1;
    data_a = 8'hFF;
    data_b = 8'hFF;
    tick();  // E0
    start  = 1'b0;
    tick();
    tick();
    tick();  // now in SHIFT cycle k=3
    check("mid_abit", {31'd0, a_bit}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("midrst_nodone%0d", i), {31'd0, done}, 32'd0);
    end

    run_add("0f01", 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
